// File: rtl/cpu_trace_checker.sv
// Streaming checker for CPU trace records "^T@PC: $G <= D#" / "^T@PC: *A <= D#", one char per clock.
// Optional saturating record/error counters are built when CPU_TRACE_CHECKER_STATS_EN is defined.
module cpu_trace_checker #(
  parameter int          TIME_DIG = 4,
  parameter int          GRF_DIG  = 4,
  parameter int          GRF_NUM  = 32,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_4fff,
  parameter logic [31:0] DM_LO    = 32'h0000_0000,
  parameter logic [31:0] DM_HI    = 32'h0000_2fff,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       char,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [15:0]      rec_time,
  output logic [31:0]      rec_pc,
  output logic [31:0]      rec_idx,
  output logic [31:0]      rec_data,
  output logic [CNT_W-1:0] rec_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  // state    | meaning
  // IDLE     | waiting for '^'            TIME   | T digits        AT    | after '@', first PC digit
  // PC       | PC hex digits, then ':'    COLON_SP | spaces, '$'/'*'  GRF  | G digits
  // ADDR     | A hex digits               PRE_LT | spaces before '<' LT  | expecting '='
  // EQ_SP    | spaces, first D digit      DATA   | D hex digits, '#'  DONE | record accepted, outputs valid
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_TIME     = 4'd1;
  localparam logic [3:0] S_AT       = 4'd2;
  localparam logic [3:0] S_PC       = 4'd3;
  localparam logic [3:0] S_COLON_SP = 4'd4;
  localparam logic [3:0] S_GRF      = 4'd5;
  localparam logic [3:0] S_ADDR     = 4'd6;
  localparam logic [3:0] S_PRE_LT   = 4'd7;
  localparam logic [3:0] S_LT       = 4'd8;
  localparam logic [3:0] S_EQ_SP    = 4'd9;
  localparam logic [3:0] S_DATA     = 4'd10;
  localparam logic [3:0] S_DONE     = 4'd11;

  localparam logic [7:0]  TDIG    = 8'(TIME_DIG);
  localparam logic [7:0]  GDIG    = 8'(GRF_DIG);
  localparam logic [7:0]  HEX8    = 8'd8;
  localparam logic [31:0] GRF_LIM = 32'(GRF_NUM);

  logic [3:0]  state_q, state_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [15:0] t_acc_q, t_acc_d;
  logic [31:0] pc_acc_q, pc_acc_d;
  logic [31:0] idx_acc_q, idx_acc_d;
  logic [31:0] data_acc_q, data_acc_d;
  logic        mem_acc_q, mem_acc_d;
  logic        accept;

  logic [15:0] rec_time_q;
  logic [31:0] rec_pc_q, rec_idx_q, rec_data_q;
  logic        rec_mem_q;
  logic [15:0] freq_q;

  logic       is_dec, is_hex;
  logic [3:0] hex_val;

  assign is_dec  = (char >= "0") && (char <= "9");
  assign is_hex  = is_dec || ((char >= "a") && (char <= "f"));
  assign hex_val = is_dec ? char[3:0] : (char[3:0] + 4'd9);

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    t_acc_d    = t_acc_q;
    pc_acc_d   = pc_acc_q;
    idx_acc_d  = idx_acc_q;
    data_acc_d = data_acc_q;
    mem_acc_d  = mem_acc_q;
    accept     = 1'b0;
    if (char == "^") begin
      state_d    = S_TIME;
      dcnt_d     = 8'd0;
      t_acc_d    = 16'd0;
      pc_acc_d   = 32'd0;
      idx_acc_d  = 32'd0;
      data_acc_d = 32'd0;
      mem_acc_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_TIME: begin
          if (is_dec && (dcnt_q < TDIG)) begin
            t_acc_d = t_acc_q * 16'd10 + {12'd0, char[3:0]};
            dcnt_d  = dcnt_q + 8'd1;
          end else if ((char == "@") && (dcnt_q != 8'd0)) begin
            state_d = S_AT;
            dcnt_d  = 8'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_AT: begin
          if (is_hex) begin
            pc_acc_d = {28'd0, hex_val};
            dcnt_d   = 8'd1;
            state_d  = S_PC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PC: begin
          if (is_hex && (dcnt_q < HEX8)) begin
            pc_acc_d = {pc_acc_q[27:0], hex_val};
            dcnt_d   = dcnt_q + 8'd1;
          end else if ((char == ":") && (dcnt_q == HEX8)) begin
            state_d = S_COLON_SP;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_COLON_SP: begin
          if (char == " ") begin
            state_d = S_COLON_SP;
          end else if (char == "$") begin
            state_d   = S_GRF;
            dcnt_d    = 8'd0;
            mem_acc_d = 1'b0;
          end else if (char == "*") begin
            state_d   = S_ADDR;
            dcnt_d    = 8'd0;
            mem_acc_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_GRF: begin
          if (is_dec && (dcnt_q < GDIG)) begin
            idx_acc_d = idx_acc_q * 32'd10 + {28'd0, char[3:0]};
            dcnt_d    = dcnt_q + 8'd1;
          end else if ((char == " ") && (dcnt_q != 8'd0)) begin
            state_d = S_PRE_LT;
          end else if ((char == "<") && (dcnt_q != 8'd0)) begin
            state_d = S_LT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          if (is_hex && (dcnt_q < HEX8)) begin
            idx_acc_d = {idx_acc_q[27:0], hex_val};
            dcnt_d    = dcnt_q + 8'd1;
          end else if ((char == " ") && (dcnt_q == HEX8)) begin
            state_d = S_PRE_LT;
          end else if ((char == "<") && (dcnt_q == HEX8)) begin
            state_d = S_LT;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRE_LT: begin
          if (char == " ")      state_d = S_PRE_LT;
          else if (char == "<") state_d = S_LT;
          else                  state_d = S_IDLE;
        end
        S_LT:    state_d = (char == "=") ? S_EQ_SP : S_IDLE;
        S_EQ_SP: begin
          if (char == " ") begin
            state_d = S_EQ_SP;
          end else if (is_hex) begin
            data_acc_d = {28'd0, hex_val};
            dcnt_d     = 8'd1;
            state_d    = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          if (is_hex && (dcnt_q < HEX8)) begin
            data_acc_d = {data_acc_q[27:0], hex_val};
            dcnt_d     = dcnt_q + 8'd1;
          end else if ((char == "#") && (dcnt_q == HEX8)) begin
            state_d = S_DONE;
            accept  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      dcnt_q     <= 8'd0;
      t_acc_q    <= 16'd0;
      pc_acc_q   <= 32'd0;
      idx_acc_q  <= 32'd0;
      data_acc_q <= 32'd0;
      mem_acc_q  <= 1'b0;
      rec_time_q <= 16'd0;
      rec_pc_q   <= 32'd0;
      rec_idx_q  <= 32'd0;
      rec_data_q <= 32'd0;
      rec_mem_q  <= 1'b0;
      freq_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      t_acc_q    <= t_acc_d;
      pc_acc_q   <= pc_acc_d;
      idx_acc_q  <= idx_acc_d;
      data_acc_q <= data_acc_d;
      mem_acc_q  <= mem_acc_d;
      if (accept) begin
        rec_time_q <= t_acc_q;
        rec_pc_q   <= pc_acc_q;
        rec_idx_q  <= idx_acc_q;
        rec_data_q <= data_acc_q;
        rec_mem_q  <= mem_acc_q;
        freq_q     <= freq;
      end
    end
  end

  // Unsigned a < b via the borrow of a 33-bit subtraction; keeps constant bounds such as 0 lint-clean.
  function automatic logic lt_u(input logic [31:0] a, input logic [31:0] b);
    lt_u = 1'(({1'b0, a} - {1'b0, b}) >> 32);
  endfunction

  logic        in_done;
  logic [15:0] t_mask;
  logic        time_bad, pc_bad, addr_bad, grf_bad;

  assign in_done  = (state_q == S_DONE);
  assign t_mask   = (freq_q < 16'd2) ? 16'd0 : ({1'b0, freq_q[15:1]} - 16'd1);
  assign time_bad = |(rec_time_q & t_mask);
  assign pc_bad   = (|rec_pc_q[1:0]) | lt_u(rec_pc_q, PC_LO) | lt_u(PC_HI, rec_pc_q);
  assign addr_bad = rec_mem_q &
                    ((|rec_idx_q[1:0]) | lt_u(rec_idx_q, DM_LO) | lt_u(DM_HI, rec_idx_q));
  assign grf_bad  = !rec_mem_q & !lt_u(rec_idx_q, GRF_LIM);

  assign format_type = in_done ? (rec_mem_q ? 2'b10 : 2'b01) : 2'b00;
  assign error_code  = in_done ? {grf_bad, addr_bad, pc_bad, time_bad} : 4'b0000;
  assign rec_time    = rec_time_q;
  assign rec_pc      = rec_pc_q;
  assign rec_idx     = rec_idx_q;
  assign rec_data    = rec_data_q;

`ifdef CPU_TRACE_CHECKER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] rec_cnt_q, err_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rec_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (in_done) begin
      if (rec_cnt_q != '1) rec_cnt_q <= rec_cnt_q + CNT_ONE;
      if ((error_code != 4'b0000) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_ONE;
    end
  end

  assign rec_cnt = rec_cnt_q;
  assign err_cnt = err_cnt_q;
`else
  assign rec_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_checker.sv
// Directed bench for cpu_trace_checker: a string-level record parser predicts every output each cycle.
module tb_cpu_trace_checker;
  localparam int    CNT_W    = 2;
  localparam int    TIME_DIG = 4;
  localparam int    GRF_DIG  = 4;
  localparam int    GRF_NUM  = 32;
  localparam longint PC_LO   = 64'h3000;
  localparam longint PC_HI   = 64'h4fff;
  localparam longint DM_LO   = 64'h0;
  localparam longint DM_HI   = 64'h2fff;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [7:0]       char;
  logic [15:0]      freq;
  logic [1:0]       format_type;
  logic [3:0]       error_code;
  logic [15:0]      rec_time;
  logic [31:0]      rec_pc, rec_idx, rec_data;
  logic [CNT_W-1:0] rec_cnt, err_cnt;

  cpu_trace_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .char(char), .freq(freq),
    .format_type(format_type), .error_code(error_code),
    .rec_time(rec_time), .rec_pc(rec_pc), .rec_idx(rec_idx), .rec_data(rec_data),
    .rec_cnt(rec_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 0;

  // expected DUT state after the next rising edge
  longint exp_fmt, exp_err, exp_time, exp_pc, exp_idx, exp_data, exp_rc, exp_ec;
  byte    rec_q[$];
  bit     have_caret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit is_d(input byte c);
    return (c >= "0") && (c <= "9");
  endfunction

  function automatic bit is_h(input byte c);
    return is_d(c) || ((c >= "a") && (c <= "f"));
  endfunction

  function automatic longint hv(input byte c);
    return is_d(c) ? longint'(c - "0") : longint'(c - "a" + 10);
  endfunction

  function automatic bit get_hex8(input byte q[$], inout int i, output longint v);
    v = 0;
    for (int k = 0; k < 8; k++) begin
      if (i >= q.size() || !is_h(q[i])) return 0;
      v = v * 16 + hv(q[i]);
      i++;
    end
    return 1;
  endfunction

  // q holds everything after '^' up to (not including) '#'
  function automatic bit parse_rec(input byte q[$], output bit is_mem, output longint t,
                                   output longint pc, output longint idx, output longint d);
    int i = 0;
    int n = 0;
    is_mem = 0; t = 0; pc = 0; idx = 0; d = 0;
    while (i < q.size() && is_d(q[i])) begin t = t * 10 + hv(q[i]); i++; n++; end
    if (n < 1 || n > TIME_DIG) return 0;
    if (i >= q.size() || q[i] != "@") return 0;
    i++;
    if (!get_hex8(q, i, pc)) return 0;
    if (i >= q.size() || q[i] != ":") return 0;
    i++;
    while (i < q.size() && q[i] == " ") i++;
    if (i >= q.size()) return 0;
    if (q[i] == "$") begin
      i++; n = 0;
      while (i < q.size() && is_d(q[i])) begin idx = idx * 10 + hv(q[i]); i++; n++; end
      if (n < 1 || n > GRF_DIG) return 0;
    end else if (q[i] == "*") begin
      i++; is_mem = 1;
      if (!get_hex8(q, i, idx)) return 0;
    end else return 0;
    while (i < q.size() && q[i] == " ") i++;
    if (i + 1 >= q.size() || q[i] != "<" || q[i+1] != "=") return 0;
    i += 2;
    while (i < q.size() && q[i] == " ") i++;
    if (!get_hex8(q, i, d)) return 0;
    return i == q.size();
  endfunction

  task automatic model_clear();
    exp_fmt = 0; exp_err = 0; exp_time = 0; exp_pc = 0; exp_idx = 0; exp_data = 0;
    exp_rc = 0; exp_ec = 0; have_caret = 0; rec_q.delete();
  endtask

  task automatic send_char(input byte c);
    bit ok, is_mem;
    longint t, pc, idx, d, mask;
    @(negedge clk);
`ifdef CPU_TRACE_CHECKER_STATS_EN
    if (exp_fmt != 0) begin
      if (exp_rc < 3) exp_rc++;
      if (exp_err != 0 && exp_ec < 3) exp_ec++;
    end
`endif
    exp_fmt = 0; exp_err = 0;
    if (c == "^") begin
      have_caret = 1; rec_q.delete();
    end else if (c == "#") begin
      ok = have_caret && parse_rec(rec_q, is_mem, t, pc, idx, d);
      if (ok) begin
        mask = (freq >= 2) ? longint'(freq) / 2 - 1 : 0;
        exp_fmt  = is_mem ? 2 : 1;
        exp_err  = 0;
        if (((t % 65536) & mask) != 0) exp_err += 1;
        if (pc % 4 != 0 || pc < PC_LO || pc > PC_HI) exp_err += 2;
        if (is_mem && (idx % 4 != 0 || idx < DM_LO || idx > DM_HI)) exp_err += 4;
        if (!is_mem && idx >= GRF_NUM) exp_err += 8;
        exp_time = t % 65536; exp_pc = pc; exp_idx = idx % 64'h1_0000_0000; exp_data = d;
      end
      have_caret = 0;
    end else if (have_caret) begin
      rec_q.push_back(c);
    end
    char = c;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    char    = 8'h00;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // sample the DONE cycle produced by the '#' just sent
  task automatic at_done();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("format_type", format_type, exp_fmt);
      chk("error_code",  error_code,  exp_err);
      chk("rec_time",    rec_time,    exp_time);
      chk("rec_pc",      rec_pc,      exp_pc);
      chk("rec_idx",     rec_idx,     exp_idx);
      chk("rec_data",    rec_data,    exp_data);
      chk("rec_cnt",     rec_cnt,     exp_rc);
      chk("err_cnt",     err_cnt,     exp_ec);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    char    = 8'h00;
    freq    = 16'd2;
    model_clear();
    @(negedge clk);
    started = 1;
    @(negedge clk);
    chk("reset_format", format_type, 2'b00);
    chk("reset_rec_pc", rec_pc, 32'h0);
    reset_n = 1'b1;

    freq = 16'd2;
    send_str("^10@00003000: $1 <= 0000000a#");
    at_done();
    chk("t1_format", format_type, 2'b01);
    chk("t1_error",  error_code, 4'b0000);
    chk("t1_idx",    rec_idx, 32'd1);
    chk("t1_data",   rec_data, 32'h0000000a);
    chk("t1_time",   rec_time, 16'd10);
    send_char(" ");

    freq = 16'd4;
    send_str("^7@00003002: *00003000 <= 12345678#");
    at_done();
    chk("t2_format", format_type, 2'b10);
    chk("t2_error",  error_code, 4'b0111);
    chk("t2_pc",     rec_pc, 32'h00003002);
    send_char("x");

    freq = 16'd32;
    send_str("^16@00004ffc:   $32   <=   ffffffff#");
    at_done();
    chk("t3_format", format_type, 2'b01);
    chk("t3_error",  error_code, 4'b1000);
    send_char(" ");

    freq = 16'd2;
    send_str("^12345@00003000: $1 <= 00000000#");
    send_str("^1@00003A00: $1 <= 00000000#");
    send_str("^2@00003000: $12345 <= 00000000#");
    send_str("^2@00003000: *0000300 <= 00000000#");
    send_char(" ");
    chk("t4_no_pulse_data", rec_data, 32'hffffffff);
    freq = 16'd8;
    send_str("^4@00003004: *00000010 <= deadbeef#");
    at_done();
    chk("t4_format", format_type, 2'b10);
    chk("t4_error",  error_code, 4'b0000);
    chk("t4_data",   rec_data, 32'hdeadbeef);
    send_char(" ");

    freq = 16'd2;
    send_str("^1@0000^2@00003000: $0 <= 00000000#");
    at_done();
    chk("t5_time", rec_time, 16'd2);
    chk("t5_idx",  rec_idx, 32'd0);

    freq = 16'd16;
    send_str("^8@00003ff0: $31 <= 00000001#^9@00003ff1: *00002ffc <= 00000002#");
    at_done();
    chk("b2b_format", format_type, 2'b10);
    chk("b2b_error",  error_code, 4'b0011);
    chk("b2b_idx",    rec_idx, 32'h00002ffc);
    send_char(" ");

    freq = 16'd2;
    send_str("^3@00003000:$5<=00000005#");
    at_done();
    chk("nospace_idx", rec_idx, 32'd5);
    send_char(" ");

    send_str("^5@00003000: $1 <=");
    do_reset();
    chk("rst_data",   rec_data, 32'h0);
    chk("rst_time",   rec_time, 16'h0);
    chk("rst_format", format_type, 2'b00);
    send_str(" 00000001#");
    send_char(" ");
    chk("rst_no_pulse_data", rec_data, 32'h0);

    freq = 16'd1;
    send_str("^3@00004000: *00002000 <= 0000abcd#");
    at_done();
    chk("f1_error", error_code, 4'b0000);
    send_char(" ");
    send_char(" ");
`ifndef CPU_TRACE_CHECKER_STATS_EN
    chk("stats_off_rec_cnt", rec_cnt, 0);
    chk("stats_off_err_cnt", err_cnt, 0);
`endif

    @(negedge clk);
    started = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
